fp2int_converter_ctrl: RTL and testbench



---
 rtl/fp2int_converter_ctrl.sv | 170 +++++++++++++++++
 tb/tb_fp2int_converter_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp2int_converter_ctrl.sv
// fp2int_converter_ctrl: dispatches an fp32 valid/ready stream round-robin onto
//   NUM_LANES ap_ctrl_hs fp->int cores and re-emits the int32 results in acceptance order.
// Latency: accept at T -> ap_start at T+1; core ap_done at T+1+L -> out_valid at T+2+L.
// Backpressure: in_ready low while the next dispatch lane is occupied; out_valid/int_data
//   hold steady until out_ready; a lane stays in HOLD (blocking reuse) until its result drains.
//
// Ports:
//   s_axi_aclk, s_axi_areset    clock, asynchronous active-high reset
//   in_valid/in_ready/fp_data   fp32 sample input stream
//   out_valid/out_ready/int_data int32 result output stream
//   ap_start/ap_ready/ap_done   per-lane ap_ctrl_hs handshake to the HLS cores
//   input_r/output_r            per-lane operand/result, lane k at [k*DATA_W +: DATA_W]
//   busy                        some lane is not IDLE
//   proto_err                   sticky: a core raised ap_done when no result was expected

module fp2int_converter_ctrl #(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = 32
) (
    input  logic                        s_axi_aclk,
    input  logic                        s_axi_areset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           fp_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           int_data,
    output logic [NUM_LANES-1:0]        ap_start,
    input  logic [NUM_LANES-1:0]        ap_ready,
    input  logic [NUM_LANES-1:0]        ap_done,
    output logic [NUM_LANES*DATA_W-1:0] input_r,
    input  logic [NUM_LANES*DATA_W-1:0] output_r,
    output logic                        busy,
    output logic                        proto_err
);

    localparam int PTR_W = $clog2(NUM_LANES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // free for dispatch
        START = 2'd1,   // ap_start asserted, waiting for ap_ready
        WAIT  = 2'd2,   // core accepted the operand, waiting for ap_done
        HOLD  = 2'd3    // result captured, waiting for its turn on the output
    } lane_state_t;

    lane_state_t              state_q [NUM_LANES];
    lane_state_t              state_d [NUM_LANES];
    logic [DATA_W-1:0]        result_q [NUM_LANES];
    logic [PTR_W-1:0]         disp_ptr;
    logic [PTR_W-1:0]         col_ptr;

    logic                     accept;
    logic                     out_xfer;
    logic [NUM_LANES-1:0]     load_in;
    logic [NUM_LANES-1:0]     load_res;
    logic [NUM_LANES-1:0]     err_set;

    // Handshake decode uses registered state only, so a lane released this
    // cycle cannot be re-dispatched until the next one.
    assign in_ready  = (state_q[disp_ptr] == IDLE);
    assign out_valid = (state_q[col_ptr] == HOLD);
    assign int_data  = result_q[col_ptr];
    assign accept    = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (state_q[k] != IDLE) begin
                busy = 1'b1;
            end
        end
    end

    // Per-lane next state. Each lane only reacts to the shared accept/transfer
    // strobes when the corresponding pointer selects it, which is what keeps
    // output order equal to acceptance order.
    always_comb begin
        load_in  = '0;
        load_res = '0;
        err_set  = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            state_d[k] = state_q[k];
        end

        for (int k = 0; k < NUM_LANES; k++) begin
            case (state_q[k])
                IDLE: begin
                    if (accept && (disp_ptr == PTR_W'(k))) begin
                        state_d[k] = START;
                        load_in[k] = 1'b1;
                    end
                    if (ap_done[k]) begin
                        err_set[k] = 1'b1;
                    end
                end
                START: begin
                    if (ap_ready[k]) begin
                        // A combinational core may finish in its start cycle.
                        if (ap_done[k]) begin
                            state_d[k]  = HOLD;
                            load_res[k] = 1'b1;
                        end else begin
                            state_d[k] = WAIT;
                        end
                    end else if (ap_done[k]) begin
                        err_set[k] = 1'b1;
                    end
                end
                WAIT: begin
                    if (ap_done[k]) begin
                        state_d[k]  = HOLD;
                        load_res[k] = 1'b1;
                    end
                end
                HOLD: begin
                    if (out_xfer && (col_ptr == PTR_W'(k))) begin
                        state_d[k] = IDLE;
                    end
                    if (ap_done[k]) begin
                        err_set[k] = 1'b1;
                    end
                end
                default: begin
                    state_d[k] = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                state_q[k]  <= IDLE;
                result_q[k] <= '0;
            end
            ap_start  <= '0;
            input_r   <= '0;
            disp_ptr  <= '0;
            col_ptr   <= '0;
            proto_err <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_LANES; k++) begin
                state_q[k]  <= state_d[k];
                // Dedicated flop so ap_start is glitch-free toward the core.
                ap_start[k] <= (state_d[k] == START);
                // Operand is written only on dispatch, so it stays stable
                // for the whole time the lane is busy.
                if (load_in[k]) begin
                    input_r[k*DATA_W +: DATA_W] <= fp_data;
                end
                if (load_res[k]) begin
                    result_q[k] <= output_r[k*DATA_W +: DATA_W];
                end
            end

            if (accept) begin
                disp_ptr <= (disp_ptr == PTR_W'(NUM_LANES - 1)) ? '0 : disp_ptr + 1'b1;
            end
            if (out_xfer) begin
                col_ptr <= (col_ptr == PTR_W'(NUM_LANES - 1)) ? '0 : col_ptr + 1'b1;
            end

            if (|err_set) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fp2int_converter_ctrl.sv
// tb_fp2int_converter_ctrl: self-checking bench for fp2int_converter_ctrl.
// Latency: n/a (bench).
// Backpressure: core models and out_ready are driven by the bench.

module tb_fp2int_converter_ctrl;

    localparam int NL = 4;
    localparam int DW = 32;

    logic              clk;
    logic              areset;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     fp_data;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     int_data;
    logic [NL-1:0]     ap_start;
    logic [NL-1:0]     model_rdy;
    logic [NL-1:0]     model_done;
    logic [NL-1:0]     spur_done;
    logic [NL-1:0]     ap_done_w;
    logic [NL*DW-1:0]  input_r;
    logic [NL*DW-1:0]  core_out;
    logic              busy;
    logic              proto_err;

    assign ap_done_w = model_done | spur_done;

    fp2int_converter_ctrl #(.NUM_LANES(NL), .DATA_W(DW)) dut (
        .s_axi_aclk   (clk),
        .s_axi_areset (areset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .fp_data      (fp_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .int_data     (int_data),
        .ap_start     (ap_start),
        .ap_ready     (model_rdy),
        .ap_done      (ap_done_w),
        .input_r      (input_r),
        .output_r     (core_out),
        .busy         (busy),
        .proto_err    (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            errors;
    int            checks;
    int            lat_cfg [NL];
    bit            rand_lat;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] out_log [$];
    logic [NL-1:0] occ;
    int            acc_cnt;
    int            col_cnt;
    int            start_cycles;

    typedef struct {
        logic [31:0] fp;
        int          lat;
        logic [31:0] exp_int;
        int          exp_cyc;
    } vec_t;

    vec_t vecs [6];

    // Truncating fp32 -> int32 conversion, saturating out-of-range magnitudes.
    function automatic logic [31:0] f2i(input logic [31:0] x);
        int          e;
        logic [54:0] m;
        logic [31:0] mag;
        e = int'(x[30:23]) - 127;
        if (e < 0) begin
            mag = '0;
        end else if (e > 30) begin
            return x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            m   = {31'd0, 1'b1, x[22:0]} << e;
            mag = m[54:23];
        end
        return x[31] ? (~mag + 32'd1) : mag;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // HLS core stand-in: takes the operand in the first ap_start cycle and
    // returns f2i(operand) with ap_done after the configured latency.
    task automatic core_model();
        bit          running [NL];
        int          cnt [NL];
        logic [31:0] op [NL];
        int          l;
        for (int k = 0; k < NL; k++) running[k] = 0;
        forever begin
            @(negedge clk);
            model_rdy  = '0;
            model_done = '0;
            if (areset) begin
                for (int k = 0; k < NL; k++) running[k] = 0;
            end else begin
                for (int k = 0; k < NL; k++) begin
                    if (running[k]) begin
                        cnt[k]--;
                        if (cnt[k] == 0) begin
                            model_done[k] = 1'b1;
                            core_out[k*DW +: DW] = f2i(op[k]);
                            running[k] = 0;
                        end
                    end else if (ap_start[k]) begin
                        op[k] = input_r[k*DW +: DW];
                        model_rdy[k] = 1'b1;
                        l = rand_lat ? int'($urandom_range(0, 5)) : lat_cfg[k];
                        if (l == 0) begin
                            model_done[k] = 1'b1;
                            core_out[k*DW +: DW] = f2i(op[k]);
                        end else begin
                            running[k] = 1;
                            cnt[k] = l;
                        end
                    end
                end
            end
        end
    endtask

    // Scoreboard: in-order expected results, plus a lane occupancy view
    // (occupied from acceptance until its result leaves) that predicts in_ready.
    task automatic monitor();
        bit          prev_stall;
        logic [31:0] prev_dat;
        prev_stall = 0;
        prev_dat   = '0;
        forever begin
            @(negedge clk);
            if (areset) begin
                exp_q.delete();
                occ        = '0;
                acc_cnt    = 0;
                col_cnt    = 0;
                prev_stall = 0;
            end else begin
                check("in_ready_vs_occupancy", in_ready, !occ[acc_cnt % NL]);
                if (prev_stall) begin
                    check("out_hold_stable", {out_valid, int_data}, {1'b1, prev_dat});
                end
                if (|ap_start) start_cycles++;
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check("out_valid_without_pending", out_valid, 1'b0);
                    end else if (out_ready) begin
                        check("out_data_order", int_data, exp_q.pop_front());
                        out_log.push_back(int_data);
                        occ[col_cnt % NL] = 1'b0;
                        col_cnt++;
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_dat   = int_data;
                if (in_valid && in_ready) begin
                    exp_q.push_back(f2i(fp_data));
                    occ[acc_cnt % NL] = 1'b1;
                    acc_cnt++;
                end
            end
        end
    endtask

    // Present one sample and return just after the edge that accepts it.
    task automatic send(input logic [31:0] d, input int budget);
        int n;
        n = 0;
        fp_data  = d;
        in_valid = 1'b1;
        while (!in_ready && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", 1'b1, 1'b0);
        end else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_complete", (exp_q.size() == 0) && !busy, 1'b1);
    endtask

    task automatic set_lat(input int l);
        for (int k = 0; k < NL; k++) lat_cfg[k] = l;
    endtask

    logic [31:0] seq_fp [8];
    logic [31:0] bp_fp  [5];

    initial begin
        int          n;
        int          s0;
        int          a0;
        int          lane0;
        logic [31:0] d0;

        errors = 0; checks = 0; start_cycles = 0;
        acc_cnt = 0; col_cnt = 0; occ = '0;
        rand_lat = 0; set_lat(1);
        model_rdy = '0; model_done = '0; spur_done = '0; core_out = '0;
        areset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; fp_data = '0;

        vecs[0] = '{fp: 32'h4049_0FDB, lat: 3, exp_int: 32'h0000_0003, exp_cyc: 5};
        vecs[1] = '{fp: 32'hC000_0000, lat: 0, exp_int: 32'hFFFF_FFFE, exp_cyc: 2};
        vecs[2] = '{fp: 32'h3F80_0000, lat: 1, exp_int: 32'h0000_0001, exp_cyc: 3};
        vecs[3] = '{fp: 32'h42F6_0000, lat: 2, exp_int: 32'h0000_007B, exp_cyc: 4};
        vecs[4] = '{fp: 32'h3F00_0000, lat: 4, exp_int: 32'h0000_0000, exp_cyc: 6};
        vecs[5] = '{fp: 32'hC2C8_0000, lat: 5, exp_int: 32'hFFFF_FF9C, exp_cyc: 7};

        seq_fp = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                   32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};
        bp_fp  = '{32'h4110_0000, 32'h4120_0000, 32'h4130_0000, 32'h4140_0000, 32'h4150_0000};

        fork
            core_model();
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ap_start", ap_start, '0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_proto_err", proto_err, 1'b0);
        check("rst_int_data", int_data, '0);
        check("rst_input_r", input_r, '0);
        areset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", in_ready, 1'b1);

        // Single samples: latency, data, one ap_start cycle, idle afterwards
        for (int i = 0; i < 6; i++) begin
            set_lat(vecs[i].lat);
            s0 = start_cycles;
            send(vecs[i].fp, 20);
            n = 1;
            while (!out_valid && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            check("vec_latency", n, vecs[i].exp_cyc);
            check("vec_int_data", int_data, vecs[i].exp_int);
            @(posedge clk); #1;
            check("vec_ap_start_cycles", start_cycles - s0, 1);
            check("vec_busy_after", busy, 1'b0);
        end
        check("comb_core_proto_err", proto_err, 1'b0);

        // Out-of-order completion, results must follow input order
        lat_cfg[0] = 6; lat_cfg[1] = 2; lat_cfg[2] = 4; lat_cfg[3] = 1;
        out_log.delete();
        for (int i = 0; i < 8; i++) send(seq_fp[i], 50);
        drain(100);
        check("ooo_count", out_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check("ooo_sequence", (out_log.size() > i) ? out_log[i] : 32'hDEAD_BEEF, i + 1);
        end

        // Backpressure: all lanes fill, fifth sample waits, output holds
        set_lat(1);
        out_ready = 1'b0;
        out_log.delete();
        a0 = acc_cnt;
        for (int i = 0; i < 4; i++) send(bp_fp[i], 20);
        fp_data  = bp_fp[4];
        in_valid = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
        end
        check("bp_accepted", acc_cnt - a0, 4);
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_out_valid", out_valid, 1'b1);
        d0 = int_data;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("bp_int_data_stable", int_data, d0);
        check("bp_head_value", int_data, 32'd9);
        in_valid = 1'b0;
        out_ready = 1'b1;
        send(bp_fp[4], 20);
        drain(100);
        check("bp_count", out_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check("bp_sequence", (out_log.size() > i) ? out_log[i] : 32'hDEAD_BEEF, i + 9);
        end

        // Randomised traffic against the scoreboard
        rand_lat = 1;
        a0 = acc_cnt;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            fp_data   = $urandom();
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain(300);
        check("rand_progress", (acc_cnt - a0) > 50, 1'b1);
        rand_lat = 0;
        check("pre_spur_proto_err", proto_err, 1'b0);

        // Spurious ap_done on idle lane 2
        spur_done = 4'b0100;
        @(posedge clk); #1;
        spur_done = '0;
        check("spur_proto_err_set", proto_err, 1'b1);
        set_lat(1);
        out_log.delete();
        send(32'h4000_0000, 20);
        drain(50);
        check("spur_flow_count", out_log.size(), 1);
        check("spur_flow_data", (out_log.size() > 0) ? out_log[0] : 32'hDEAD_BEEF, 32'd2);
        check("spur_proto_err_sticky", proto_err, 1'b1);

        // Reset with three lanes waiting and one holding a result
        lane0 = acc_cnt % NL;
        for (int k = 0; k < NL; k++) lat_cfg[k] = (k == lane0) ? 0 : 40;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(seq_fp[i], 20);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("pre_rst_out_valid", out_valid, 1'b1);
        check("pre_rst_ap_start", ap_start, '0);
        check("pre_rst_busy", busy, 1'b1);
        areset = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_input_r", input_r, '0);
        check("mid_rst_proto_err", proto_err, 1'b0);
        check("mid_rst_ap_start", ap_start, '0);
        repeat (2) @(posedge clk);
        #1;
        areset = 1'b0;
        out_ready = 1'b1;
        set_lat(2);
        out_log.delete();
        @(posedge clk); #1;
        send(32'h4040_0000, 20);
        check("post_rst_lane0_start", ap_start, 4'b0001);
        check("post_rst_lane0_operand", input_r[31:0], 32'h4040_0000);
        drain(50);
        check("post_rst_count", out_log.size(), 1);
        check("post_rst_data", (out_log.size() > 0) ? out_log[0] : 32'hDEAD_BEEF, 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
